// File: rtl/lsu.sv
// Load/store unit: byte/half/word accesses onto a word-wide data memory,
// with read-modify-write for sub-word stores and rejection of bad accesses.
module lsu #(
   parameter int DM_AW    = 16,
   parameter int DM_WORDS = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             resp_valid,
   output logic [31:0]      resp_rdata,
   output logic             resp_err,
   output logic [DM_AW-1:0] dm_addr,
   output logic [31:0]      dm_wd,
   output logic             dm_we,
   input  logic [31:0]      dm_rd
);

   localparam logic [31:0] WORDS_LIM = 32'(DM_WORDS);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t state, next;

   logic             we_q;
   logic [1:0]       size_q;
   logic             uns_q;
   logic [1:0]       lo_q;
   logic [31:0]      wdata_q;
   logic [DM_AW-1:0] idx_q;
   logic             err_q;
   logic [31:0]      rd_q;

   logic             accept;
   logic             acc_err;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [31:0]      load_val;
   logic [31:0]      merged;

   assign accept = req_valid & req_ready;

   always_comb begin
      acc_err = 1'b0;
      case (req_size)
         2'b01:   acc_err = req_addr[0];
         2'b10:   acc_err = |req_addr[1:0];
         2'b11:   acc_err = 1'b1;
         default: acc_err = 1'b0;
      endcase
      if ({2'b00, req_addr[31:2]} >= WORDS_LIM)
         acc_err = 1'b1;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst)
         state <= IDLE;
      else
         state <= next;
   end

   // Next-state logic
   always_comb begin
      next = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (acc_err)
                  next = RESP;
               else if (!req_we || req_size != 2'b10)
                  next = READ;
               else
                  next = WRITE;
            end
         end
         READ:    next = we_q ? WRITE : RESP;
         WRITE:   next = RESP;
         RESP:    next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         we_q    <= 1'b0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         lo_q    <= '0;
         wdata_q <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
         rd_q    <= '0;
      end else begin
         if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            lo_q    <= req_addr[1:0];
            wdata_q <= req_wdata;
            idx_q   <= req_addr[DM_AW+1:2];
            err_q   <= acc_err;
         end
         if (state == READ)
            rd_q <= dm_rd;
      end
   end

   always_comb begin
      case (lo_q)
         2'd0:    byte_sel = rd_q[7:0];
         2'd1:    byte_sel = rd_q[15:8];
         2'd2:    byte_sel = rd_q[23:16];
         default: byte_sel = rd_q[31:24];
      endcase
      half_sel = lo_q[1] ? rd_q[31:16] : rd_q[15:0];
      case (size_q)
         2'b00:   load_val = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         2'b01:   load_val = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: load_val = rd_q;
      endcase
   end

   always_comb begin
      merged = rd_q;
      case (size_q)
         2'b00: begin
            case (lo_q)
               2'd0:    merged[7:0]   = wdata_q[7:0];
               2'd1:    merged[15:8]  = wdata_q[7:0];
               2'd2:    merged[23:16] = wdata_q[7:0];
               default: merged[31:24] = wdata_q[7:0];
            endcase
         end
         2'b01: begin
            if (lo_q[1])
               merged[31:16] = wdata_q[15:0];
            else
               merged[15:0] = wdata_q[15:0];
         end
         default: merged = wdata_q;
      endcase
   end

   // Output logic; the write strobe is also gated by reset so an aborted
   // WRITE never reaches memory.
   always_comb begin
      req_ready  = rst && (state == IDLE);
      dm_we      = rst && (state == WRITE);
      resp_valid = (state == RESP);
      resp_err   = (state == RESP) && err_q;
      resp_rdata = (state == RESP && !we_q && !err_q) ? load_val : '0;
      dm_addr    = idx_q;
      dm_wd      = merged;
   end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu with a 32-word behavioural data memory.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [15:0] dm_addr;
   logic [31:0] dm_wd;
   logic        dm_we;
   logic [31:0] dm_rd;

   logic [31:0] mem [0:31];
   logic        preload;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int we_cnt = 0;
   int rv_cnt = 0;
   int acc_cnt = 0;
   int acc_last = 0;
   int acc_prev = 0;

   always #5 clk = ~clk;

   lsu #(.DM_AW(16), .DM_WORDS(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_we(dm_we), .dm_rd(dm_rd)
   );

   assign dm_rd = (dm_addr < 16'd32) ? mem[dm_addr[4:0]] : '0;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (dm_we) we_cnt = we_cnt + 1;
      if (resp_valid) rv_cnt = rv_cnt + 1;
      if (req_valid && req_ready) begin
         acc_cnt  = acc_cnt + 1;
         acc_prev = acc_last;
         acc_last = cyc;
      end
      if (preload) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
         mem[3] <= 32'h8899AABB;
      end else if (dm_we) begin
         mem[dm_addr[4:0]] <= dm_wd;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Presents one request for a single accept edge; returns at the negedge of T+1.
   task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      chk("ready_at_issue", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] exp);
      drive(1'b0, size, uns, addr, 32'h0);
      chk({tag, "_t1_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_t1_ready"}, {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk({tag, "_t2_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, "_t2_rdata"}, resp_rdata, exp);
      chk({tag, "_t2_err"}, {31'd0, resp_err}, 32'd0);
      @(negedge clk);
      chk({tag, "_t3_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_t3_rdata"}, resp_rdata, 32'd0);
   endtask

   task automatic do_err(input string tag, input logic we, input logic [1:0] size,
                         input logic [31:0] addr);
      int w0;
      w0 = we_cnt;
      drive(we, size, 1'b0, addr, 32'h12345678);
      chk({tag, "_t1_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, "_t1_err"}, {31'd0, resp_err}, 32'd1);
      chk({tag, "_t1_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_t1_we"}, {31'd0, dm_we}, 32'd0);
      @(negedge clk);
      chk({tag, "_t2_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_t2_err"}, {31'd0, resp_err}, 32'd0);
      chk({tag, "_we_count"}, we_cnt - w0, 32'd0);
   endtask

   initial begin
      int w0;
      int r0;
      int a0;
      rst          = 1'b0;
      preload      = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      repeat (2) @(negedge clk);
      preload = 1'b0;
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", {31'd0, resp_err}, 32'd0);
      chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
      chk("rst_dm_addr", {16'd0, dm_addr}, 32'd0);
      chk("rst_dm_wd", dm_wd, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

      // Loads from word 3 = 0x8899AABB
      do_load("lb_0d",  2'b00, 1'b0, 32'h0D, 32'hFFFFFFAA);
      do_load("lbu_0d", 2'b00, 1'b1, 32'h0D, 32'h000000AA);
      do_load("lb_0c",  2'b00, 1'b0, 32'h0C, 32'hFFFFFFBB);
      do_load("lh_0e",  2'b01, 1'b0, 32'h0E, 32'hFFFF8899);
      do_load("lhu_0c", 2'b01, 1'b1, 32'h0C, 32'h0000AABB);
      do_load("lw_0c",  2'b10, 1'b0, 32'h0C, 32'h8899AABB);

      // Byte store into lane 2 of word 3
      drive(1'b1, 2'b00, 1'b0, 32'h0E, 32'h11223344);
      chk("sb_t1_we", {31'd0, dm_we}, 32'd0);
      chk("sb_t1_valid", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      chk("sb_t2_we", {31'd0, dm_we}, 32'd1);
      chk("sb_t2_addr", {16'd0, dm_addr}, 32'd3);
      chk("sb_t2_wd", dm_wd, 32'h8844AABB);
      chk("sb_t2_valid", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      chk("sb_t3_valid", {31'd0, resp_valid}, 32'd1);
      chk("sb_t3_we", {31'd0, dm_we}, 32'd0);
      chk("sb_t3_rdata", resp_rdata, 32'd0);
      chk("sb_t3_err", {31'd0, resp_err}, 32'd0);
      chk("sb_mem3", mem[3], 32'h8844AABB);
      do_load("lw_after_sb", 2'b10, 1'b0, 32'h0C, 32'h8844AABB);

      // Word store restoring word 3
      drive(1'b1, 2'b10, 1'b0, 32'h0C, 32'h8899AABB);
      chk("sw_t1_we", {31'd0, dm_we}, 32'd1);
      chk("sw_t1_wd", dm_wd, 32'h8899AABB);
      @(negedge clk);
      chk("sw_t2_valid", {31'd0, resp_valid}, 32'd1);
      chk("sw_t2_we", {31'd0, dm_we}, 32'd0);
      chk("sw_mem3", mem[3], 32'h8899AABB);

      // Rejected accesses
      do_err("err_sw_0d", 1'b1, 2'b10, 32'h0D);
      do_err("err_lh_0f", 1'b0, 2'b01, 32'h0F);
      do_err("err_size11", 1'b0, 2'b11, 32'h0C);
      do_err("err_lw_80", 1'b0, 2'b10, 32'h80);
      do_err("err_sb_80", 1'b1, 2'b00, 32'h81);
      chk("err_mem3", mem[3], 32'h8899AABB);

      // Reset during READ of a halfword store
      w0 = we_cnt;
      r0 = rv_cnt;
      drive(1'b1, 2'b01, 1'b0, 32'h0C, 32'h0000CAFE);
      chk("abort_in_read_we", {31'd0, dm_we}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_rst_ready", {31'd0, req_ready}, 32'd0);
      chk("abort_rst_valid", {31'd0, resp_valid}, 32'd0);
      chk("abort_rst_we", {31'd0, dm_we}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
      repeat (3) @(negedge clk);
      chk("abort_we_count", we_cnt - w0, 32'd0);
      chk("abort_rv_count", rv_cnt - r0, 32'd0);
      chk("abort_mem3", mem[3], 32'h8899AABB);

      // Back-to-back with req_valid held high: lw 0x0C then sw 0x10
      a0 = acc_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h0C; req_wdata = 32'h0;
      chk("b2b_ready_t0", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
      chk("b2b_ready_t1", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("b2b_lw_valid", {31'd0, resp_valid}, 32'd1);
      chk("b2b_lw_rdata", resp_rdata, 32'h8899AABB);
      chk("b2b_ready_t2", {31'd0, req_ready}, 32'd0);
      chk("b2b_acc_t2", acc_cnt - a0, 32'd1);
      @(negedge clk);
      chk("b2b_ready_t3", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b_acc_count", acc_cnt - a0, 32'd2);
      chk("b2b_acc_spacing", acc_last - acc_prev, 32'd3);
      chk("b2b_sw_we", {31'd0, dm_we}, 32'd1);
      chk("b2b_sw_addr", {16'd0, dm_addr}, 32'd4);
      chk("b2b_sw_wd", dm_wd, 32'hDEADBEEF);
      @(negedge clk);
      chk("b2b_sw_valid", {31'd0, resp_valid}, 32'd1);
      chk("b2b_sw_rdata", resp_rdata, 32'd0);
      @(negedge clk);
      chk("b2b_mem4", mem[4], 32'hDEADBEEF);
      chk("b2b_acc_final", acc_cnt - a0, 32'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
